// File: rtl/cpu_debug_ocimem_arbiter.sv
// cpu_debug_ocimem_arbiter: shares the single-port OCI debug RAM between the
// JTAG debug path (one-deep pending slot) and a local host debug port.
module cpu_debug_ocimem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   jtag_addr;
    logic                pend_valid;
    logic                pend_we;
    logic [DATA_W-1:0]   pend_wdata;
    logic                last_jtag;   // last grant went to JTAG (0 = HOST)
    logic                own_jtag;    // current access belongs to JTAG
    logic                own_we;      // current access is a write

    logic cmd_a;
    logic cmd_na;
    logic cmd_b;
    logic cmd_queue;
    logic jtag_busy;
    logic jtag_done;
    logic grant_jtag;
    logic grant_host;

    // jdo bits outside the address/data/read-flag fields carry nothing here
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // Strobe priority b > no_action_a > a, slot occupancy and completion decode
    always_comb begin
        cmd_b     = take_action_ocimem_b;
        cmd_na    = take_no_action_ocimem_a & ~take_action_ocimem_b;
        cmd_a     = take_action_ocimem_a & ~take_action_ocimem_b & ~take_no_action_ocimem_a;
        cmd_queue = cmd_b | cmd_na | (cmd_a & jdo[35]);
        jtag_busy = pend_valid | (own_jtag & (state != IDLE));
        jtag_done = own_jtag & (((state == ACCESS) & own_we) | (state == RDATA));
    end

    // Round-robin grant decision, only meaningful in IDLE
    always_comb begin
        grant_jtag = 1'b0;
        grant_host = 1'b0;
        if (state == IDLE) begin
            if (pend_valid && host_req) begin
                grant_jtag = ~last_jtag;
                grant_host = last_jtag;
            end else if (pend_valid) begin
                grant_jtag = 1'b1;
            end else if (host_req) begin
                grant_host = 1'b1;
            end
        end
    end

    // Host samples its request fields in the same IDLE cycle it sees the grant
    assign host_gnt = grant_host;

    // JTAG capture, address pointer, overrun/ready flags and access sequencing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            jtag_addr     <= '0;
            pend_valid    <= 1'b0;
            pend_we       <= 1'b0;
            pend_wdata    <= '0;
            last_jtag     <= 1'b0;
            own_jtag      <= 1'b0;
            own_we        <= 1'b0;
            host_rvalid   <= 1'b0;
            host_rdata    <= '0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            ram_we        <= 1'b0;
            ram_re        <= 1'b0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            jtag_overrun  <= 1'b0;
        end else begin
            ram_we      <= 1'b0;
            ram_re      <= 1'b0;
            host_rvalid <= 1'b0;

            // An address load wins over the post-increment of an issuing access
            if (cmd_a) begin
                jtag_addr <= jdo[18 +: ADDR_W];
            end else if (grant_jtag) begin
                jtag_addr <= jtag_addr + ADDR_W'(1);
            end

            if (grant_jtag) begin
                pend_valid <= 1'b0;
            end
            if (cmd_queue) begin
                if (jtag_busy) begin
                    jtag_overrun <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend_we    <= cmd_b;
                    pend_wdata <= DATA_W'(jdo[34:3]);
                end
            end
            if (cmd_a && !jdo[35]) begin
                jtag_overrun <= 1'b0;
            end

            if (cmd_queue && !jtag_busy) begin
                monitor_ready <= 1'b0;
            end else if (jtag_done && !pend_valid) begin
                monitor_ready <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant_jtag || grant_host) begin
                        state     <= ACCESS;
                        own_jtag  <= grant_jtag;
                        last_jtag <= grant_jtag;
                        if (grant_jtag) begin
                            own_we    <= pend_we;
                            ram_addr  <= jtag_addr;
                            ram_wdata <= pend_wdata;
                            ram_we    <= pend_we;
                            ram_re    <= ~pend_we;
                        end else begin
                            own_we    <= host_we;
                            ram_addr  <= host_addr;
                            ram_wdata <= host_wdata;
                            ram_we    <= host_we;
                            ram_re    <= ~host_we;
                        end
                    end
                end
                ACCESS: begin
                    state <= own_we ? IDLE : RDATA;
                end
                RDATA: begin
                    state <= IDLE;
                    if (own_jtag) begin
                        MonDReg <= ram_rdata;
                    end else begin
                        host_rdata  <= ram_rdata;
                        host_rvalid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_debug_ocimem_arbiter.md
# cpu_debug_ocimem_arbiter

Arbitrates single-port access to the CPU debug on-chip memory (OCI RAM, 256 x 32) between two requesters:
- the JTAG debug path, driven by the sysclk-domain `take_action_ocimem_*` command strobes and `jdo` data;
- a local host debug port.

The block captures JTAG commands into a one-deep pending slot, grants the RAM round-robin, sequences read/write cycles, and returns JTAG read data on `MonDReg` with a `monitor_ready` flag. It sits between the debug slave's sysclk side and the OCI RAM.

## Interface
Parameters:
- ADDR_W, 8, OCI RAM word-address width.
- DATA_W, 32, OCI RAM data width (fixed to 32 by the `jdo` layout).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- take_action_ocimem_a  in  1  JTAG pulse: load address `jdo[25:18]`; if `jdo[35]`=1 also queue a read.
- take_no_action_ocimem_a  in  1  JTAG pulse: queue a read at the current JTAG address.
- take_action_ocimem_b  in  1  JTAG pulse: queue a write of `jdo[34:3]` at the current JTAG address.
- jdo  in  38  JTAG data, valid with the strobes.
- host_req  in  1  host request; held until `host_gnt`.
- host_we  in  1  host write (1) / read (0).
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  one-cycle pulse: host request accepted.
- host_rvalid  out  1  one-cycle pulse: `host_rdata` valid.
- host_rdata  out  DATA_W  host read data, held until the next host read.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_we  out  1  registered write enable.
- ram_re  out  1  registered read enable.
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after `ram_re`.
- MonDReg  out  DATA_W  last JTAG read data.
- monitor_ready  out  1  0 while a JTAG command is pending or executing, 1 otherwise.
- jtag_overrun  out  1  sticky: a JTAG command was dropped.

## Operation
- Reset values: all outputs 0 except `monitor_ready`=1. Internally: state=IDLE, JTAG address=0, pending slot empty, last_grant=HOST (so JTAG wins the first tie).
- **JTAG capture:**
  - `take_action_ocimem_a` always loads the address, even when the slot is full.
  - Any queued command clears `monitor_ready`.
  - A command arriving while the slot is full or JTAG is executing is dropped and sets `jtag_overrun`.
  - `jtag_overrun` clears only when `take_action_ocimem_a` arrives with `jdo[35]`=0.
  - If more than one strobe occurs in a cycle, priority is `b` > `no_action_a` > `a`.
- **JTAG addressing:** after each JTAG access issues, the JTAG address post-increments modulo 256 (255 -> 0). Host accesses do not move it.
- **FSM states:** IDLE, ACCESS, RDATA.
  - IDLE: if exactly one requester is pending, grant it. If both, grant the one not in `last_grant`. Then go to ACCESS.
  - ACCESS: `ram_*` driven for this one cycle. Write goes to IDLE; read goes to RDATA.
  - RDATA: capture `ram_rdata` into `MonDReg` or `host_rdata`, go to IDLE.
- **Host grant:** `host_gnt` pulses in the IDLE cycle in which the grant is decided. The host samples `host_we`, `host_addr` and `host_wdata` in that cycle.
- **JTAG completion:** `monitor_ready` returns to 1 in the cycle after the ACCESS cycle for a write, or after the RDATA cycle for a read, unless a new JTAG command was captured meanwhile.
- **Reset mid-operation:** an in-flight access is abandoned and no completion or `rvalid` is produced.

## Timing
- Grant in cycle N (IDLE), RAM strobe in cycle N+1, read data captured at the end of N+2. `host_rvalid` is high in cycle N+3; `MonDReg` updates in N+3.
- Minimum spacing between grants: 2 cycles for a write, 3 for a read. After each grant, `last_grant` is updated.
- A JTAG strobe in cycle N can be granted in cycle N+1 at the earliest.
- `ram_we` and `ram_re` are never both 1.

## Test plan
- **Reset:** `reset_n`=0 -> all outputs 0, `monitor_ready`=1. Release, idle 5 cycles -> no `ram_we`/`ram_re`.
- **JTAG write then read-back:**
  - Apply `take_action_ocimem_a` with `jdo[25:18]`=0x10, `jdo[35]`=0.
  - Apply `take_action_ocimem_b` with `jdo[34:3]`=0xDEADBEEF -> `ram_we` with `ram_addr`=0x10.
  - Reload addr 0x10 with `jdo[35]`=1 -> `ram_re` at 0x10, `MonDReg`=0xDEADBEEF, `monitor_ready`=1.
- **Host read:** `host_req`, `host_we`=0, `host_addr`=0x20, RAM holds 0x12345678 -> `host_gnt` at N, `ram_re` at N+1, `host_rvalid` with 0x12345678 at N+3.
- **Contention:** JTAG pending and `host_req` both asserted continuously -> grants alternate JTAG, HOST, JTAG, HOST.
- **Wrap and overrun:**
  - JTAG address 0xFF, issue two reads -> `ram_addr` 0xFF then 0x00.
  - Issue `take_no_action_ocimem_a` twice back-to-back while busy -> second dropped, `jtag_overrun`=1.
- **Reset mid-read:** assert `reset_n`=0 in the RDATA cycle -> no `host_rvalid`, `MonDReg`=0, `monitor_ready`=1.
